// File: rtl/port_tx_serializer.sv
// Captures every change of the CPU output port p1 into a small FIFO and sends each word
// on a UART-style line: start bit, 16 data bits LSB first, stop bit.
module port_tx_serializer #(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            p1,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   prev;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] baud, baud_n;
  logic [3:0]    bitcnt, bitcnt_n;
  logic [15:0]   shift, shift_n;
  logic          tx_n;
  logic          capture, push, pop, baud_end;

  // A full FIFO still takes a word when the serializer pops in the same cycle.
  assign capture  = (p1 != prev);
  assign push     = capture && ((level < FULL) || pop);
  assign baud_end = (baud == BAUD_LAST);
  assign busy     = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) prev <= p1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (capture && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= p1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
      tx     <= 1'b1;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      bitcnt <= bitcnt_n;
      shift  <= shift_n;
      tx     <= tx_n;
    end
  end

  // tx_n is the line level for the next cycle, so tx only moves on bit boundaries.
  always_comb begin
    state_n  = state;
    baud_n   = baud_end ? '0 : baud + 1'b1;
    bitcnt_n = bitcnt;
    shift_n  = shift;
    tx_n     = tx;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (level != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n  = DATA;
          bitcnt_n = '0;
          tx_n     = shift[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bitcnt == 4'd15) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bitcnt_n = bitcnt + 1'b1;
            shift_n  = {1'b0, shift[15:1]};
            tx_n     = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (level != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
